// File: rtl/game_pkg.sv
// Shared definitions for the game sequencer and the object position/time counter.
//   game_state_t     : top-level game states
//   POS_W / TIME_W   : widths shared with the counter stage
//   DEFAULT_WRAP_POS : object position at which an obstacle wave counts as complete
package game_pkg;

    typedef enum logic [2:0] {
        MENU,
        PLAY,
        HIT,
        WON,
        LOST
    } game_state_t;

    localparam int unsigned POS_W            = 10;
    localparam int unsigned TIME_W           = 16;
    localparam int unsigned DEFAULT_WRAP_POS = 680;

endpackage

// File: rtl/rise_edge.sv
// Registered rising-edge detector.
//   clk   : system clock
//   reset : synchronous active-low reset, loads the history register with RESET_VAL
//   d     : level input
//   rise  : high for the cycle where d is 1 and was 0 on the previous clk
// A RESET_VAL of 1 suppresses an edge for a level already high when reset is released.
module rise_edge #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic rise
);

    logic d_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            d_q <= RESET_VAL;
        end else begin
            d_q <= d;
        end
    end

    assign rise = d & ~d_q;

endmodule

// File: rtl/game_state_ctrl.sv
// Top-level game sequencer.
//   clk, reset           : clock and synchronous active-low reset
//   start_btn            : synchronised start/continue button level
//   collision            : player/obstacle overlap from the collision checker
//   obj_position_counter : object position read back from the counter stage
//   menuScreen / playerWon / playerLost : registered state flags for the counter stage
//   reset_obj_count      : single-cycle pulse restarting the object sweep
//   level, lives_left    : 0-based level and remaining lives
//   invulnerable         : high while recovering from a hit
module game_state_ctrl
    import game_pkg::*;
#(
    parameter int unsigned LIVES           = 3,
    parameter int unsigned WAVES_PER_LEVEL = 4,
    parameter int unsigned NUM_LEVELS      = 3,
    parameter int unsigned HIT_CYCLES      = 60,
    parameter int unsigned WRAP_POS        = DEFAULT_WRAP_POS
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_btn,
    input  logic             collision,
    input  logic [POS_W-1:0] obj_position_counter,
    output logic             menuScreen,
    output logic             playerWon,
    output logic             playerLost,
    output logic             reset_obj_count,
    output logic [1:0]       level,
    output logic [2:0]       lives_left,
    output logic             invulnerable
);

    localparam int unsigned WAVE_W = (WAVES_PER_LEVEL > 1) ? $clog2(WAVES_PER_LEVEL) : 1;
    localparam int unsigned HIT_W  = $clog2(HIT_CYCLES + 1);

    localparam logic [WAVE_W-1:0] LAST_WAVE  = WAVE_W'(WAVES_PER_LEVEL - 1);
    localparam logic [1:0]        LAST_LEVEL = 2'(NUM_LEVELS - 1);
    localparam logic [2:0]        LIVES_INIT = 3'(LIVES);
    localparam logic [HIT_W-1:0]  HIT_LOAD   = HIT_W'(HIT_CYCLES - 1);
    localparam logic [POS_W-1:0]  WRAP_THR   = POS_W'(WRAP_POS);

    game_state_t       state_q, state_d;
    logic [1:0]        level_q, level_d;
    logic [2:0]        lives_q, lives_d;
    logic [WAVE_W-1:0] wave_q, wave_d;
    logic [HIT_W-1:0]  hit_q, hit_d;
    logic              restart;

    logic menu_q, won_q, lost_q, rst_obj_q, inv_q;

    logic start_rise;
    logic wrap_rise;
    logic wave_last;
    logic level_last;

    // Button history resets high so a button held through reset cannot start a game.
    rise_edge #(
        .RESET_VAL (1'b1)
    ) u_start_edge (
        .clk   (clk),
        .reset (reset),
        .d     (start_btn),
        .rise  (start_rise)
    );

    // One event per contiguous run at or above the wrap position.
    rise_edge #(
        .RESET_VAL (1'b0)
    ) u_wrap_edge (
        .clk   (clk),
        .reset (reset),
        .d     (obj_position_counter >= WRAP_THR),
        .rise  (wrap_rise)
    );

    assign wave_last  = (wave_q == LAST_WAVE);
    assign level_last = (level_q == LAST_LEVEL);

    always_comb begin
        state_d = state_q;
        level_d = level_q;
        lives_d = lives_q;
        wave_d  = wave_q;
        hit_d   = hit_q;
        restart = 1'b0;

        unique case (state_q)
            MENU: begin
                if (start_rise) begin
                    state_d = PLAY;
                    lives_d = LIVES_INIT;
                    level_d = 2'd0;
                    wave_d  = '0;
                end
            end

            PLAY: begin
                if (collision) begin
                    if (lives_q == 3'd1) begin
                        state_d = LOST;
                        lives_d = 3'd0;
                    end else begin
                        state_d = HIT;
                        lives_d = lives_q - 3'd1;
                        hit_d   = HIT_LOAD;
                        restart = 1'b1;
                    end
                end else if (wrap_rise) begin
                    if (!wave_last) begin
                        wave_d = wave_q + WAVE_W'(1);
                    end else if (level_last) begin
                        state_d = WON;
                    end else begin
                        level_d = level_q + 2'd1;
                        wave_d  = '0;
                        restart = 1'b1;
                    end
                end
            end

            HIT: begin
                if (hit_q == '0) begin
                    state_d = PLAY;
                end else begin
                    hit_d = hit_q - HIT_W'(1);
                end
                // Assigned after the countdown so a win overrides hit expiry.
                if (wrap_rise) begin
                    if (!wave_last) begin
                        wave_d = wave_q + WAVE_W'(1);
                    end else if (level_last) begin
                        state_d = WON;
                    end else begin
                        level_d = level_q + 2'd1;
                        wave_d  = '0;
                        restart = 1'b1;
                    end
                end
            end

            WON, LOST: begin
                if (start_rise) begin
                    state_d = MENU;
                end
            end

            default: begin
                state_d = MENU;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= MENU;
            level_q   <= 2'd0;
            lives_q   <= LIVES_INIT;
            wave_q    <= '0;
            hit_q     <= '0;
            menu_q    <= 1'b1;
            won_q     <= 1'b0;
            lost_q    <= 1'b0;
            rst_obj_q <= 1'b0;
            inv_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            level_q   <= level_d;
            lives_q   <= lives_d;
            wave_q    <= wave_d;
            hit_q     <= hit_d;
            menu_q    <= (state_d == MENU);
            won_q     <= (state_d == WON);
            lost_q    <= (state_d == LOST);
            // A hit right after a level advance (or vice versa) must not stretch the pulse.
            rst_obj_q <= restart & ~rst_obj_q;
            inv_q     <= (state_d == HIT);
        end
    end

    assign menuScreen      = menu_q;
    assign playerWon       = won_q;
    assign playerLost      = lost_q;
    assign reset_obj_count = rst_obj_q;
    assign level           = level_q;
    assign lives_left      = lives_q;
    assign invulnerable    = inv_q;

endmodule

// File: tb/tb_game_state_ctrl.sv
// Self-checking bench for game_state_ctrl (default parameters).
module tb_game_state_ctrl;

    localparam int MD_MENU = 0;
    localparam int MD_PLAY = 1;
    localparam int MD_HIT  = 2;
    localparam int MD_WON  = 3;
    localparam int MD_LOST = 4;

    localparam int N_LIVES  = 3;
    localparam int N_WAVES  = 4;
    localparam int N_LEVELS = 3;
    localparam int N_HIT    = 60;
    localparam int N_WRAP   = 680;

    logic       clk = 1'b0;
    logic       reset;
    logic       start_btn;
    logic       collision;
    logic [9:0] pos;
    logic       menuScreen, playerWon, playerLost, reset_obj_count, invulnerable;
    logic [1:0] level;
    logic [2:0] lives_left;

    int n_checks = 0;
    int n_fail   = 0;
    bit use_model = 0;

    // Behavioural model: game progress kept as total waves cleared.
    int m_mode, m_lives, m_level, m_total, m_hit;
    bit m_start_prev, m_hi_prev, m_pulse;

    game_state_ctrl dut (
        .clk                  (clk),
        .reset                (reset),
        .start_btn            (start_btn),
        .collision            (collision),
        .obj_position_counter (pos),
        .menuScreen           (menuScreen),
        .playerWon            (playerWon),
        .playerLost           (playerLost),
        .reset_obj_count      (reset_obj_count),
        .level                (level),
        .lives_left           (lives_left),
        .invulnerable         (invulnerable)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit r, s, c;
        int p;
        bit menu, won, lost, ro;
        int lvl, lives;
        bit inv;
    } vec_t;

    function automatic logic [9:0] pack(bit m, bit w, bit l, bit r, int lv, int li, bit inv);
        logic [1:0] lv2;
        logic [2:0] li3;
        lv2 = lv[1:0];
        li3 = li[2:0];
        return {m, w, l, r, lv2, li3, inv};
    endfunction

    task automatic model_reset();
        m_mode = MD_MENU; m_lives = N_LIVES; m_level = 0; m_total = 0; m_hit = 0;
        m_start_prev = 1; m_hi_prev = 0; m_pulse = 0;
    endtask

    task automatic model_wrap(inout bit want);
        m_total++;
        if (m_total == N_WAVES * N_LEVELS) begin
            m_mode = MD_WON;
        end else begin
            m_level = m_total / N_WAVES;
            if (m_total % N_WAVES == 0) want = 1;
        end
    endtask

    task automatic model_clock(input bit r, input bit s, input bit c, input int p);
        bit st_edge, hi, wrap, want;
        if (!r) begin
            model_reset();
            return;
        end
        st_edge = s && !m_start_prev;
        hi = (p >= N_WRAP);
        wrap = hi && !m_hi_prev;
        want = 0;
        m_start_prev = s;
        m_hi_prev = hi;
        case (m_mode)
            MD_MENU: if (st_edge) begin
                m_mode = MD_PLAY; m_lives = N_LIVES; m_level = 0; m_total = 0;
            end
            MD_PLAY: begin
                if (c) begin
                    if (m_lives == 1) begin
                        m_mode = MD_LOST; m_lives = 0;
                    end else begin
                        m_mode = MD_HIT; m_lives--; m_hit = N_HIT; want = 1;
                    end
                end else if (wrap) begin
                    model_wrap(want);
                end
            end
            MD_HIT: begin
                if (wrap) model_wrap(want);
                if (m_mode == MD_HIT) begin
                    m_hit--;
                    if (m_hit == 0) m_mode = MD_PLAY;
                end
            end
            default: if (st_edge) m_mode = MD_MENU;
        endcase
        m_pulse = want && !m_pulse;
    endtask

    function automatic logic [9:0] model_vec();
        return pack(m_mode == MD_MENU, m_mode == MD_WON, m_mode == MD_LOST, m_pulse,
                    m_level, m_lives, m_mode == MD_HIT);
    endfunction

    task automatic check(input string name, input logic [9:0] exp);
        logic [9:0] got;
        got = {menuScreen, playerWon, playerLost, reset_obj_count, level, lives_left,
               invulnerable};
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got menu/won/lost/rst=%b%b%b%b level=%0d lives=%0d inv=%b, want menu/won/lost/rst=%b%b%b%b level=%0d lives=%0d inv=%b",
                     name, $time, got[9], got[8], got[7], got[6], got[5:4], got[3:1], got[0],
                     exp[9], exp[8], exp[7], exp[6], exp[5:4], exp[3:1], exp[0]);
        end
    endtask

    task automatic check_val(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0d, want %0d", name, $time, got, exp);
        end
    endtask

    task automatic tick(input bit r, input bit s, input bit c, input int p);
        reset = r; start_btn = s; collision = c; pos = p[9:0];
        model_clock(r, s, c, p);
        @(posedge clk);
        #1;
        if (use_model) check("model", model_vec());
    endtask

    vec_t tbl[22];
    int   inv_cnt;
    int   rp;

    initial begin
        reset = 0; start_btn = 1; collision = 0; pos = '0;
        model_reset();

        //               r  s  c  pos   menu won lost ro lvl lives inv
        tbl[0]  = '{0, 1, 0, 0,   1, 0, 0, 0, 0, 3, 0};
        tbl[1]  = '{1, 1, 0, 0,   1, 0, 0, 0, 0, 3, 0};
        tbl[2]  = '{1, 0, 0, 0,   1, 0, 0, 0, 0, 3, 0};
        tbl[3]  = '{1, 1, 0, 0,   0, 0, 0, 0, 0, 3, 0};
        tbl[4]  = '{1, 1, 0, 700, 0, 0, 0, 0, 0, 3, 0};
        tbl[5]  = '{1, 1, 0, 700, 0, 0, 0, 0, 0, 3, 0};
        tbl[6]  = '{1, 1, 0, 700, 0, 0, 0, 0, 0, 3, 0};
        tbl[7]  = '{1, 0, 0, 0,   0, 0, 0, 0, 0, 3, 0};
        tbl[8]  = '{1, 0, 0, 680, 0, 0, 0, 0, 0, 3, 0};
        tbl[9]  = '{1, 0, 0, 679, 0, 0, 0, 0, 0, 3, 0};
        tbl[10] = '{1, 0, 0, 680, 0, 0, 0, 0, 0, 3, 0};
        tbl[11] = '{1, 0, 0, 0,   0, 0, 0, 0, 0, 3, 0};
        tbl[12] = '{1, 0, 0, 690, 0, 0, 0, 1, 1, 3, 0};
        tbl[13] = '{1, 0, 0, 0,   0, 0, 0, 0, 1, 3, 0};
        tbl[14] = '{1, 0, 0, 680, 0, 0, 0, 0, 1, 3, 0};
        tbl[15] = '{1, 0, 0, 0,   0, 0, 0, 0, 1, 3, 0};
        tbl[16] = '{1, 0, 0, 680, 0, 0, 0, 0, 1, 3, 0};
        tbl[17] = '{1, 0, 0, 0,   0, 0, 0, 0, 1, 3, 0};
        tbl[18] = '{1, 0, 0, 680, 0, 0, 0, 0, 1, 3, 0};
        tbl[19] = '{1, 0, 0, 0,   0, 0, 0, 0, 1, 3, 0};
        tbl[20] = '{1, 0, 1, 680, 0, 0, 0, 1, 1, 2, 1};
        tbl[21] = '{1, 0, 0, 0,   0, 0, 0, 0, 1, 2, 1};

        for (int i = 0; i < 22; i++) begin
            tick(tbl[i].r, tbl[i].s, tbl[i].c, tbl[i].p);
            check($sformatf("vec%0d", i),
                  pack(tbl[i].menu, tbl[i].won, tbl[i].lost, tbl[i].ro, tbl[i].lvl,
                       tbl[i].lives, tbl[i].inv));
        end

        use_model = 1;

        // Invulnerability window, with a collision inside it that must be ignored.
        inv_cnt = 2;
        for (int i = 0; i < 100; i++) begin
            tick(1, 0, i == 5, 0);
            if (!invulnerable) break;
            inv_cnt++;
        end
        check_val("hit_len", inv_cnt, N_HIT);
        check_val("hit_lives", int'(lives_left), 2);
        // Wave count survived the discarded wrap: one more wrap advances the level.
        tick(1, 0, 0, 680);
        check_val("adv_level", int'(level), 2);
        check_val("adv_pulse", int'(reset_obj_count), 1);
        tick(1, 0, 0, 0);
        check_val("pulse_single", int'(reset_obj_count), 0);

        // Lose remaining lives.
        tick(1, 0, 1, 0);
        check_val("lives1", int'(lives_left), 1);
        for (int i = 0; i < 100 && invulnerable; i++) tick(1, 0, 0, 0);
        check_val("hit_expired", int'(invulnerable), 0);
        tick(1, 0, 1, 0);
        check("lost", pack(0, 0, 1, 0, 2, 0, 0));
        tick(1, 1, 0, 0);
        check_val("lost_to_menu", int'(menuScreen), 1);

        // Full win: 12 waves.
        tick(1, 0, 0, 0);
        tick(1, 1, 0, 0);
        check_val("win_play", int'(menuScreen), 0);
        for (int w = 1; w <= N_WAVES * N_LEVELS; w++) begin
            tick(1, 1, 0, 700);
            if (w == N_WAVES * N_LEVELS - 1) check_val("not_won_yet", int'(playerWon), 0);
            tick(1, 1, 0, 0);
        end
        check("won", pack(0, 1, 0, 0, 2, 3, 0));
        tick(0, 0, 0, 0);
        check("reset_in_won", pack(1, 0, 0, 0, 0, 3, 0));

        // Randomised play against the model.
        rp = 0;
        for (int i = 0; i < 4000; i++) begin
            bit r, s, c;
            r = ($urandom_range(0, 599) != 0);
            s = ($urandom_range(0, 7) == 0);
            c = ($urandom_range(0, 149) == 0);
            if ($urandom_range(0, 4) != 0) rp += int'($urandom_range(0, 60));
            if (rp >= 720) rp = 0;
            tick(r, s, c, rp);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
